// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display. It steps the digit select,
// drives the anodes with a blanking window, and commits new digits only at frame boundaries.
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  output logic [1:0]  s,
  output logic [3:0]  I0,
  output logic [3:0]  I1,
  output logic [3:0]  I2,
  output logic [3:0]  I3,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        upd_pending
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [15:0]   pend_data;
  logic          tick;
  logic          boundary;
  logic          in_dead;

  assign tick     = en && (cnt == CNT_LAST);
  assign boundary = tick && (s == 2'd3);

  // With no dead window the comparison would be constant, so drop it entirely.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
      assign in_dead = (cnt < DEAD_C);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      s   <= 2'd0;
    end else if (!en || tick) begin
      cnt <= '0;
      if (tick) s <= s + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // An upd arriving on the boundary edge itself is committed directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data   <= 16'h0000;
      upd_pending <= 1'b0;
      frame_done  <= 1'b0;
      {I3, I2, I1, I0} <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      if (upd) pend_data <= data;
      if (boundary && (upd || upd_pending)) begin
        {I3, I2, I1, I0} <= upd ? data : pend_data;
        upd_pending      <= 1'b0;
        frame_done       <= 1'b1;
      end else if (upd) begin
        upd_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    an = 4'b1111;
    if (en && !in_dead && !blank[s]) an = ~(4'b0001 << s);
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_DIV=8, DEAD=2: a table of
// scan/anode vectors followed by hand-written update, bypass and reset sequences.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        upd;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [1:0]  s;
  logic [3:0]  I0, I1, I2, I3;
  logic [3:0]  an;
  logic        frame_done;
  logic        upd_pending;

  int tests = 0;
  int fails = 0;
  int fd_count = 0;

  disp_scan_ctrl #(.SCAN_DIV(8), .DEAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd(upd), .data(data), .blank(blank),
    .s(s), .I0(I0), .I1(I1), .I2(I2), .I3(I3), .an(an),
    .frame_done(frame_done), .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  typedef struct {
    int         adv;
    logic       en;
    logic [3:0] blank;
    logic [1:0] exp_s;
    logic [3:0] exp_an;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the scan position matches; a timeout counts as a failure.
  task automatic go_to(input logic [1:0] ts, input logic [2:0] tc);
    int n;
    n = 0;
    while (!(s == ts && dut.cnt == tc) && n < 64) begin
      step(1);
      n++;
    end
    if (n >= 64) chk("goto_timeout", 32'(n), 32'(0));
  endtask

  function automatic logic [3:0] mux_o();
    case (s)
      2'd0: return I0;
      2'd1: return I1;
      2'd2: return I2;
      default: return I3;
    endcase
  endfunction

  initial begin
    logic [3:0] exp_o[4];

    // adv, en, blank, s, an
    vecs.push_back('{0, 1'b1, 4'b0000, 2'd0, 4'b1111});
    vecs.push_back('{1, 1'b1, 4'b0000, 2'd0, 4'b1111});
    vecs.push_back('{1, 1'b1, 4'b0000, 2'd0, 4'b1110});
    vecs.push_back('{5, 1'b1, 4'b0000, 2'd0, 4'b1110});
    vecs.push_back('{1, 1'b1, 4'b0000, 2'd1, 4'b1111});
    vecs.push_back('{2, 1'b1, 4'b0000, 2'd1, 4'b1101});
    vecs.push_back('{6, 1'b1, 4'b0000, 2'd2, 4'b1111});
    vecs.push_back('{2, 1'b1, 4'b0000, 2'd2, 4'b1011});
    vecs.push_back('{6, 1'b1, 4'b0000, 2'd3, 4'b1111});
    vecs.push_back('{2, 1'b1, 4'b0000, 2'd3, 4'b0111});
    vecs.push_back('{6, 1'b1, 4'b0000, 2'd0, 4'b1111});
    vecs.push_back('{2, 1'b1, 4'b0000, 2'd0, 4'b1110});
    // digit 2 blanked
    vecs.push_back('{8, 1'b1, 4'b0100, 2'd1, 4'b1101});
    vecs.push_back('{8, 1'b1, 4'b0100, 2'd2, 4'b1111});
    vecs.push_back('{0, 1'b1, 4'b0000, 2'd2, 4'b1011});
    vecs.push_back('{0, 1'b1, 4'b0100, 2'd2, 4'b1111});
    vecs.push_back('{5, 1'b1, 4'b0100, 2'd2, 4'b1111});
    vecs.push_back('{3, 1'b1, 4'b0000, 2'd3, 4'b0111});
    // enable dropped mid-slot at s=1
    vecs.push_back('{17, 1'b1, 4'b0000, 2'd1, 4'b1101});
    vecs.push_back('{0, 1'b0, 4'b0000, 2'd1, 4'b1111});
    vecs.push_back('{5, 1'b0, 4'b0000, 2'd1, 4'b1111});
    vecs.push_back('{0, 1'b1, 4'b0000, 2'd1, 4'b1111});
    vecs.push_back('{2, 1'b1, 4'b0000, 2'd1, 4'b1101});
    vecs.push_back('{5, 1'b1, 4'b0000, 2'd1, 4'b1101});
    vecs.push_back('{1, 1'b1, 4'b0000, 2'd2, 4'b1111});

    rst_n = 1'b0; en = 1'b1; upd = 1'b0; data = 16'h0000; blank = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_s", 32'(s), 32'(0));
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_I", 32'({I3, I2, I1, I0}), 32'h0);
    chk("reset_pend", 32'(upd_pending), 32'(0));
    chk("reset_fd", 32'(frame_done), 32'(0));
    rst_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      en = vecs[v].en;
      blank = vecs[v].blank;
      if (vecs[v].adv == 0) #1;
      else step(vecs[v].adv);
      chk($sformatf("vec%0d_s", v), 32'(s), 32'(vecs[v].exp_s));
      chk($sformatf("vec%0d_an", v), 32'(an), 32'(vecs[v].exp_an));
    end
    chk("idle_I", 32'({I3, I2, I1, I0}), 32'h0);
    chk("idle_fd_count", 32'(fd_count), 32'(0));

    // Framed commit
    go_to(2'd1, 3'd3);
    upd = 1'b1; data = 16'h5A5A;
    step(1);
    upd = 1'b0;
    chk("commit_pend_set", 32'(upd_pending), 32'(1));
    chk("commit_I_old", 32'({I3, I2, I1, I0}), 32'h0);
    go_to(2'd3, 3'd7);
    chk("commit_pend_hold", 32'(upd_pending), 32'(1));
    chk("commit_I_hold", 32'({I3, I2, I1, I0}), 32'h0);
    step(1);
    chk("commit_I", 32'({I3, I2, I1, I0}), 32'h5A5A);
    chk("commit_pend_clr", 32'(upd_pending), 32'(0));
    chk("commit_fd", 32'(frame_done), 32'(1));
    chk("commit_s", 32'(s), 32'(0));
    step(1);
    chk("commit_fd_once", 32'(frame_done), 32'(0));
    exp_o[0] = 4'hA; exp_o[1] = 4'h5; exp_o[2] = 4'hA; exp_o[3] = 4'h5;
    for (int d = 0; d < 4; d++) begin
      go_to(2'(d), 3'd4);
      chk($sformatf("mux_o_s%0d", d), 32'(mux_o()), 32'(exp_o[d]));
    end
    chk("commit_fd_count", 32'(fd_count), 32'(1));

    // Overwrite before the boundary
    go_to(2'd0, 3'd5);
    upd = 1'b1; data = 16'h1234;
    step(1);
    upd = 1'b0;
    go_to(2'd2, 3'd1);
    upd = 1'b1; data = 16'hABCD;
    step(1);
    upd = 1'b0;
    go_to(2'd3, 3'd7);
    chk("ovr_pend", 32'(upd_pending), 32'(1));
    chk("ovr_I_hold", 32'({I3, I2, I1, I0}), 32'h5A5A);
    step(1);
    chk("ovr_I", 32'({I3, I2, I1, I0}), 32'hABCD);
    chk("ovr_fd", 32'(frame_done), 32'(1));
    chk("ovr_pend_clr", 32'(upd_pending), 32'(0));

    // Bypass: upd on the boundary cycle
    go_to(2'd3, 3'd7);
    chk("byp_pend_before", 32'(upd_pending), 32'(0));
    upd = 1'b1; data = 16'h0F0F;
    step(1);
    upd = 1'b0;
    chk("byp_I", 32'({I3, I2, I1, I0}), 32'h0F0F);
    chk("byp_pend", 32'(upd_pending), 32'(0));
    chk("byp_fd", 32'(frame_done), 32'(1));
    step(1);
    chk("byp_pend_after", 32'(upd_pending), 32'(0));
    chk("byp_fd_count", 32'(fd_count), 32'(3));

    // Reset while an update is pending at s=2
    go_to(2'd1, 3'd6);
    upd = 1'b1; data = 16'h3C3C;
    step(1);
    upd = 1'b0;
    go_to(2'd2, 3'd3);
    chk("rst_pre_pend", 32'(upd_pending), 32'(1));
    chk("rst_pre_an", 32'(an), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_s", 32'(s), 32'(0));
    chk("rst_async_an", 32'(an), 32'hF);
    chk("rst_async_I", 32'({I3, I2, I1, I0}), 32'h0);
    chk("rst_async_pend", 32'(upd_pending), 32'(0));
    chk("rst_async_fd", 32'(frame_done), 32'(0));
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(40);
    chk("rst_no_commit_I", 32'({I3, I2, I1, I0}), 32'h0);
    chk("rst_no_commit_fd", 32'(fd_count), 32'(3));
    chk("rst_run_s", 32'(s), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
